regfile_writeback_23rv: RTL
===========================

# regfile_writeback_23rv

Writeback arbiter and write-port driver for the 23RV register file. It collects results from the ALU and load-unit producers through valid/ready channels, buffers each in a 2-entry FIFO, and arbitrates round-robin. It issues at most one registered write per cycle on the regfile `rd`/`wd`/`we` port. It also provides a pending-destination mask and forwarding for the write in flight.

## Interface
- `ADDRESS_BITWIDTH`, 5, register index width; 2^ADDRESS_BITWIDTH registers.
- `DATA_WIDTH`, 32, result/write data width.
- `FIFO_DEPTH`, 2, entries per producer FIFO; fixed at 2, other values unsupported.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset; one clock, sampled on `clk`.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU channel can accept.
- `alu_rd`  in  ADDRESS_BITWIDTH  ALU destination register.
- `alu_data`  in  DATA_WIDTH  ALU result.
- `ld_valid`  in  1  load result present.
- `ld_ready`  out  1  load channel can accept.
- `ld_rd`  in  ADDRESS_BITWIDTH  load destination register.
- `ld_data`  in  DATA_WIDTH  load result.
- `we`  out  1  regfile write enable (registered).
- `rd`  out  ADDRESS_BITWIDTH  regfile write address (registered).
- `wd`  out  DATA_WIDTH  regfile write data (registered).
- `rs1`, `rs2`  in  ADDRESS_BITWIDTH  decode-stage source indices for forwarding.
- `fwd1_hit`, `fwd2_hit`  out  1  source matches the write in flight.
- `fwd1_data`, `fwd2_data`  out  DATA_WIDTH  forwarded value (equals `wd`).
- `pend_mask`  out  2^ADDRESS_BITWIDTH  bit r set if register r has a result not yet committed.

## Operation
- Per channel: 2-entry FIFO (head/tail pointers plus 2-bit count).
- Push on `X_valid && X_ready` at the edge.
- `X_ready = (count_X != 2)`. This is a function of state only, with no valid-to-ready combinational path.
- Arbiter looks at the FIFO heads each cycle:
  - Only one head non-empty: that head is granted.
  - Both heads non-empty: the one not granted last is granted.
  - `last_grant` (0=ALU, 1=LD) is updated on every grant; reset value 0, so the load unit wins the first contest.
- Granted head pops at the edge and loads the output register: `we<=1`, `rd<=head_rd`, `wd<=head_data`.
- No grant: `we<=0`; `rd`/`wd` hold their previous values.
- Destination x0: the entry is accepted and arbitrated normally, but the output register loads `we<=0`. Grant and pop still occur.
- Push and pop on the same channel in the same edge: count unchanged, ordering preserved. Push to an empty FIFO is not visible to the arbiter until the next cycle; there is no bypass.
- `pend_mask[r]` = OR over valid FIFO entries of (entry_rd==r) OR (`we` && `rd`==r). It is combinational from state, and bit 0 is always 0.
- `fwdN_hit = we && (rd == rsN) && (rsN != 0)`; `fwdN_data = wd`.
- Reset (`reset_n` low at an edge), including in the middle of a stream:
  - Both counts and pointers are cleared and buffered entries are discarded.
  - `we=0`, `rd=0`, `wd=0`, `last_grant=0`.
  - Handshakes presented in that cycle are ignored.

## Timing
- Reset values of all outputs: `alu_ready=1`, `ld_ready=1`, `we=0`, `rd=0`, `wd=0`, `fwd*_hit=0`, `fwd*_data=0`, `pend_mask=0`.
- Latency, uncontested: accept at edge N → `we` high during cycle N+1..N+2 → regfile holds value after edge N+2.
- Throughput: one write per cycle total. One channel can sustain 1/cycle alone; under contention each channel gets 1/2.
- Starvation bound: an entry at a contested head is granted within 2 cycles.
- FIFO full: ready is low starting the cycle after the second push, and returns high the cycle after a pop.
- Per-channel order is preserved. Cross-channel order is arbitration order.

## Test plan
- ALU only, push rd=5 data=0xDEADBEEF at edge 0 → `we=1 rd=5 wd=0xDEADBEEF` in cycle 1; `pend_mask[5]=1` in cycles 0–1 and 0 after edge 2.
- Both channels valid every cycle, ALU rd=1..4, LD rd=11..14 → writes alternate LD,ALU,LD,ALU; each ready deasserts once its FIFO fills; no loss, per-channel order is 1,2,3,4 and 11,12,13,14.
- LD push rd=0 data=0x1234 → entry popped, `we` stays 0, `pend_mask=0` throughout, `ld_ready` stays 1.
- Write rd=7 data=0xA5A5A5A5 in flight with `rs1=7`, `rs2=0` → `fwd1_hit=1 fwd1_data=0xA5A5A5A5`, `fwd2_hit=0`.
- Fill both FIFOs (4 entries), assert `reset_n=0` for one edge → next cycle both readies 1, `we=0`, `pend_mask=0`, and no stale writes appear afterwards.

Source files
------------

// File: rtl/regfile_writeback_23rv.sv
// Writeback arbiter for the 23RV register file: two 2-deep result FIFOs,
// round-robin grant, registered write port, pending mask and forwarding.
module regfile_writeback_23rv #(
  parameter int ADDRESS_BITWIDTH = 5,
  parameter int DATA_WIDTH       = 32,
  parameter int FIFO_DEPTH       = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             alu_valid,
  output logic                             alu_ready,
  input  logic [ADDRESS_BITWIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]            alu_data,
  input  logic                             ld_valid,
  output logic                             ld_ready,
  input  logic [ADDRESS_BITWIDTH-1:0]      ld_rd,
  input  logic [DATA_WIDTH-1:0]            ld_data,
  output logic                             we,
  output logic [ADDRESS_BITWIDTH-1:0]      rd,
  output logic [DATA_WIDTH-1:0]            wd,
  input  logic [ADDRESS_BITWIDTH-1:0]      rs1,
  input  logic [ADDRESS_BITWIDTH-1:0]      rs2,
  output logic                             fwd1_hit,
  output logic                             fwd2_hit,
  output logic [DATA_WIDTH-1:0]            fwd1_data,
  output logic [DATA_WIDTH-1:0]            fwd2_data,
  output logic [(1<<ADDRESS_BITWIDTH)-1:0] pend_mask
);
  localparam int AW = ADDRESS_BITWIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t       mem  [2][2];
  logic       hd   [2];
  logic       tl   [2];
  logic [1:0] cnt  [2];
  ent_t       din  [2];
  logic       vld  [2];
  logic       rdy  [2];
  logic       push [2];
  logic       pop  [2];
  logic       ne0, ne1;
  logic       last_grant;
  logic       gnt_any, gnt_ld;
  ent_t       head;

  // channel 0 is the ALU, channel 1 the load unit
  assign din[0] = '{rd: alu_rd, data: alu_data};
  assign din[1] = '{rd: ld_rd, data: ld_data};
  assign vld[0] = alu_valid;
  assign vld[1] = ld_valid;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      rdy[c]  = cnt[c] != FULL;
      push[c] = vld[c] && rdy[c];
    end
  end

  assign alu_ready = rdy[0];
  assign ld_ready  = rdy[1];
  assign ne0 = cnt[0] != 2'd0;
  assign ne1 = cnt[1] != 2'd0;

  always_comb begin
    gnt_any = 1'b0;
    gnt_ld  = 1'b0;
    unique case (1'b1)
      (ne0 && ne1): begin
        gnt_any = 1'b1;
        gnt_ld  = ~last_grant;
      end
      (ne0 && !ne1): gnt_any = 1'b1;
      (!ne0 && ne1): begin
        gnt_any = 1'b1;
        gnt_ld  = 1'b1;
      end
      default: ;
    endcase
    pop[0] = gnt_any && !gnt_ld;
    pop[1] = gnt_any && gnt_ld;
    head   = gnt_ld ? mem[1][hd[1]] : mem[0][hd[0]];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        hd[c]  <= 1'b0;
        tl[c]  <= 1'b0;
        cnt[c] <= 2'd0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem[c][tl[c]] <= din[c];
          tl[c]         <= ~tl[c];
        end
        if (pop[c]) hd[c] <= ~hd[c];
        cnt[c] <= cnt[c] + {1'b0, push[c]}
                         - {1'b0, pop[c]};
      end
    end
  end

  // x0 results are still granted and popped, only the write is squashed
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we         <= 1'b0;
      rd         <= '0;
      wd         <= '0;
      last_grant <= 1'b0;
    end else if (gnt_any) begin
      we         <= head.rd != '0;
      rd         <= head.rd;
      wd         <= head.data;
      last_grant <= gnt_ld;
    end else begin
      we <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int c = 0; c < 2; c++) begin
      for (int e = 0; e < 2; e++) begin
        if (cnt[c] == FULL ||
            (cnt[c] == 2'd1 && hd[c] == e[0]))
          pend_mask[mem[c][e].rd] = 1'b1;
      end
    end
    if (we) pend_mask[rd] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  assign fwd1_hit  = we && (rd == rs1) && (rs1 != '0);
  assign fwd2_hit  = we && (rd == rs2) && (rs2 != '0);
  assign fwd1_data = wd;
  assign fwd2_data = wd;

endmodule
